// File: rtl/banana_pkg.sv
// banana_pkg: shared types and widths for the banana pickup controller.
//   state_e         : controller states IDLE, PLAY, BONUS, REARM
//   DEF_NUM_BANANAS : default number of banana sprites per level
//   COUNT_W         : width of a 0..DEF_NUM_BANANAS count
//   LIVES_W         : width of the life counter
package banana_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    BONUS,
    REARM
  } state_e;

  localparam int DEF_NUM_BANANAS = 5;
  localparam int COUNT_W         = $clog2(DEF_NUM_BANANAS + 1);
  localparam int LIVES_W         = 3;

endpackage

// File: rtl/banana_popcount.sv
// banana_popcount: combinational population count of the collected mask.
// Ports:
//   vec_i   [N-1:0]  input vector
//   count_o [W-1:0]  number of set bits in vec_i
module banana_popcount
  import banana_pkg::*;
#(
  parameter int N = DEF_NUM_BANANAS,
  parameter int W = COUNT_W
) (
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] count_o
);

  always_comb begin
    count_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      count_o = count_o + W'(vec_i[i]);
    end
  end

endmodule

// File: rtl/banana_collect_ctrl.sv
// banana_collect_ctrl: per-level banana pickup sequencer.
// Collision flags are latched into a collected mask once per frame tick; the
// mask is popcounted for the HUD. A full mask starts a timed bonus phase that
// ends by awarding a life (saturating) and re-arming the level.
// Ports:
//   Clk, Reset     clock; synchronous active-high reset
//   frame_clk      vsync-rate level; rising edge = frame tick
//   level_start    one-cycle pulse, starts/restarts the level
//   collide        per-banana overlap flags
//   banana_mask    collected bananas
//   banana_count   registered popcount of banana_mask
//   bonus_flash    HUD flash during BONUS
//   lives          current life count
//   playing        high in PLAY
//   pickup_pulse   (only with BANANA_SOUND_EN) one-cycle pulse on a new pickup
module banana_collect_ctrl
  import banana_pkg::*;
#(
  parameter int NUM_BANANAS  = DEF_NUM_BANANAS,
  parameter int BONUS_FRAMES = 60,
  parameter int START_LIVES  = 3,
  parameter int MAX_LIVES    = 7
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   frame_clk,
  input  logic                   level_start,
  input  logic [NUM_BANANAS-1:0] collide,
  output logic [NUM_BANANAS-1:0] banana_mask,
  output logic [2:0]             banana_count,
  output logic                   bonus_flash,
  output logic [2:0]             lives,
`ifdef BANANA_SOUND_EN
  output logic                   pickup_pulse,
`endif
  output logic                   playing
);

  localparam int CW = $clog2(NUM_BANANAS + 1);
  localparam int FW = $clog2(BONUS_FRAMES);

  state_e                 state_q, state_d;
  logic [NUM_BANANAS-1:0] mask_q, mask_d;
  logic [CW-1:0]          count_q, count_d;
  logic [CW-1:0]          pop;
  logic [FW-1:0]          fcnt_q, fcnt_d;
  logic [LIVES_W-1:0]     lives_q, lives_d;
  logic                   frame_q;
  logic                   rst_dly_q;
  logic                   tick;

  // rst_dly_q masks a tick on the first cycle after reset releases.
  assign tick = frame_clk & ~frame_q & ~rst_dly_q;

  banana_popcount #(
    .N(NUM_BANANAS),
    .W(CW)
  ) u_popcount (
    .vec_i  (mask_q),
    .count_o(pop)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      count_q   <= '0;
      fcnt_q    <= '0;
      lives_q   <= LIVES_W'(START_LIVES);
      frame_q   <= 1'b0;
      rst_dly_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      count_q   <= count_d;
      fcnt_q    <= fcnt_d;
      lives_q   <= lives_d;
      frame_q   <= frame_clk;
      rst_dly_q <= 1'b0;
    end
  end

  // The count normally lags the mask by one cycle, but it is cleared together
  // with the mask so a stale full count cannot re-enter BONUS from PLAY.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    count_d = pop;
    fcnt_d  = fcnt_q;
    lives_d = lives_q;
    if (level_start) begin
      state_d = PLAY;
      mask_d  = '0;
      count_d = '0;
      fcnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: ;
        PLAY: begin
          if (tick) begin
            mask_d = mask_q | collide;
          end
          if (count_q == CW'(NUM_BANANAS)) begin
            state_d = BONUS;
            fcnt_d  = '0;
          end
        end
        BONUS: begin
          if (tick) begin
            if (fcnt_q == FW'(BONUS_FRAMES - 1)) begin
              state_d = REARM;
            end else begin
              fcnt_d = fcnt_q + FW'(1);
            end
          end
        end
        REARM: begin
          if (lives_q < LIVES_W'(MAX_LIVES)) begin
            lives_d = lives_q + LIVES_W'(1);
          end
          mask_d  = '0;
          count_d = '0;
          fcnt_d  = '0;
          state_d = PLAY;
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef BANANA_SOUND_EN
  logic pulse_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= ~level_start & (state_q == PLAY) & tick & (|(collide & ~mask_q));
    end
  end

  assign pickup_pulse = pulse_q;
`endif

  assign banana_mask  = mask_q;
  assign banana_count = 3'(count_q);
  assign bonus_flash  = (state_q == BONUS) && fcnt_q[3];
  assign lives        = lives_q;
  assign playing      = (state_q == PLAY);

endmodule
